// File: rtl/alu_stim_checker.sv
// alu_stim_checker
//   Initiator side of the tile's 8-bit adder ALU interface, used as the
//   on-chip self-test companion to the ALU top. Each run walks N_VECTORS
//   operand pairs taken from an 8-bit Galois LFSR. For each pair it drives
//   the operands, waits SETTLE_CYCLES, then samples result_in and compares
//   it with (A+B) mod 256. It also keeps a saturating mismatch count.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   start      level-sampled run request (honoured only in IDLE / DONE)
//   op_a       operand A toward the ALU dedicated inputs
//   op_b       operand B toward the ALU bidirectional pins
//   op_b_oe    op_b output enable, 8'hFF while a vector is in flight
//   result_in  ALU sum output
//   busy       run in progress
//   done       run finished (held until the next start)
//   pass       valid with done: no mismatches in the run
//   err_count  mismatches in current/last run, saturating at 8'hFF
//   vec_idx    index of the vector in flight
module alu_stim_checker #(
    parameter int         N_VECTORS     = 16,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] SEED          = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [7:0] op_b_oe,
    input  logic [7:0] result_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] vec_idx
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_IDX = 8'(N_VECTORS - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;
    logic [3:0] settle_cnt;
    logic [7:0] expected;
    logic [7:0] err_chk;
    logic       accept;
    logic       last_vec;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [7:0] operand_b(input logic [7:0] l);
        return {l[4:0], l[7:5]} ^ 8'h5A;
    endfunction

    always_comb begin
        lfsr_nxt = lfsr_step(lfsr);
        expected = op_a + op_b;  // carry dropped by the 8-bit target
        accept   = start && (state == S_IDLE || state == S_DONE);
        last_vec = (vec_idx == LAST_IDX);
        err_chk  = err_count;
        if (result_in != expected && err_count != 8'hFF)
            err_chk = err_count + 8'd1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_DRIVE;
            S_DRIVE:  state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == 4'd1) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = last_vec ? S_DONE : S_DRIVE;
            S_DONE:   if (accept) state_nxt = S_DRIVE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and datapath. Operands are loaded on the edge that
    // enters DRIVE, so they are stable with op_b_oe high across
    // DRIVE/SETTLE/CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= 8'h00;
            op_b       <= 8'h00;
            op_b_oe    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'h00;
            vec_idx    <= 8'h00;
            lfsr       <= SEED_EFF;
            settle_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        lfsr      <= SEED_EFF;
                        err_count <= 8'h00;
                        vec_idx   <= 8'h00;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        op_a      <= SEED_EFF;
                        op_b      <= operand_b(SEED_EFF);
                        op_b_oe   <= 8'hFF;
                    end
                end
                S_DRIVE:  settle_cnt <= SETTLE_LD;
                S_SETTLE: settle_cnt <= settle_cnt - 4'd1;
                S_CHECK: begin
                    err_count <= err_chk;
                    lfsr      <= lfsr_nxt;
                    if (last_vec) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_chk == 8'h00);
                        op_b_oe <= 8'h00;
                    end else begin
                        vec_idx <= vec_idx + 8'd1;
                        op_a    <= lfsr_nxt;
                        op_b    <= operand_b(lfsr_nxt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
